vga_plot_arbiter: RTL and testbench

Parametrised pixel-write arbiter that sits between several drawing engines (board reset, tile draw, line colouring, correct/incorrect feedback, score overlay) and the `vga_adapter`. It replaces the ad-hoc priority mux and OR-ed plot enable in the draw master. It adds:

- a per-channel request/grant handshake;
- selectable fixed-priority or round-robin arbitration;
- burst locking, so one engine owns the frame buffer for a whole shape;
- screen-bounds clipping with a saturating clip counter.

It drives `x`, `y`, `colour` and `plot` of the adapter through one register stage.

---
 rtl/vga_plot_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_vga_plot_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_plot_arbiter.sv
`timescale 1ns/1ps
// vga_plot_arbiter
// Shares the vga_adapter pixel-write port between several drawing engines
// (board reset, tile draw, line colouring, feedback, score overlay).
// Each engine raises req[i] with its pixel on x_in/y_in/colour_in. In any
// cycle where req[i] && grant[i], that pixel is accepted. Raising lock[i]
// with an accepted pixel keeps ownership, so a whole shape is drawn before
// any other engine gets a turn.
//
// Ports:
//   clock, resetn        50 MHz clock and asynchronous active-low reset
//   req, lock            per-channel request and keep-ownership flags
//   x_in, y_in,          packed per-channel pixel data; channel i occupies
//   colour_in            bits [i*W +: W] of each bus
//   grant                one-hot or zero acceptance strobe (combinational)
//   busy, owner          registered LOCKED flag and the locked channel index
//   x, y, colour, plot   registered pixel write to the adapter
//   clip_count           saturating count of rejected off-screen pixels
module vga_plot_arbiter #(
  parameter int N_CH    = 5,
  parameter int X_W     = 9,
  parameter int Y_W     = 8,
  parameter int C_W     = 3,
  parameter int X_MAX   = 319,
  parameter int Y_MAX   = 239,
  parameter int RR_MODE = 0
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic [N_CH-1:0]     req,
  input  logic [N_CH-1:0]     lock,
  input  logic [N_CH*X_W-1:0] x_in,
  input  logic [N_CH*Y_W-1:0] y_in,
  input  logic [N_CH*C_W-1:0] colour_in,
  output logic [N_CH-1:0]     grant,
  output logic                busy,
  output logic [2:0]          owner,
  output logic [X_W-1:0]      x,
  output logic [Y_W-1:0]      y,
  output logic [C_W-1:0]      colour,
  output logic                plot,
  output logic [15:0]         clip_count
);

  typedef enum logic {IDLE, LOCKED} state_t;

  localparam logic [X_W-1:0] X_LIM = X_W'(X_MAX);
  localparam logic [Y_W-1:0] Y_LIM = Y_W'(Y_MAX);

  state_t          state_q, state_d;
  logic [2:0]      owner_q, owner_d;
  logic [2:0]      ptr_q, ptr_d;
  logic [N_CH-1:0] grant_arb;
  logic            accept;
  logic [2:0]      acc_idx;
  logic [X_W-1:0]  x_sel;
  logic [Y_W-1:0]  y_sel;
  logic [C_W-1:0]  c_sel;
  logic            in_bounds;

  // Free arbitration used while nobody owns the frame buffer. Round robin
  // starts its search one past the last accepted channel, so the channel
  // that just wrote becomes the lowest priority.
  always_comb begin
    logic       found;
    logic [2:0] idx;
    grant_arb = '0;
    found     = 1'b0;
    idx       = '0;
    if (RR_MODE != 0) begin
      for (int k = 1; k <= N_CH; k++) begin
        idx = 3'((int'(ptr_q) + k) % N_CH);
        if (!found && req[idx]) begin
          grant_arb[idx] = 1'b1;
          found          = 1'b1;
        end
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (!found && req[i]) begin
          grant_arb[i] = 1'b1;
          found        = 1'b1;
        end
      end
    end
  end

  // While locked only the owner can be granted; if it pauses its requests
  // everyone else stalls rather than sneaking pixels into the middle of a shape.
  always_comb begin
    grant = '0;
    if (resetn) begin
      if (state_q == LOCKED) begin
        grant[owner_q] = req[owner_q];
      end else begin
        grant = grant_arb;
      end
    end
  end

  // Grant only ever covers requesting channels, so any grant bit is an accept.
  // This also picks out the accepted channel's pixel and checks it against
  // the screen.
  always_comb begin
    accept  = |grant;
    acc_idx = '0;
    x_sel   = '0;
    y_sel   = '0;
    c_sel   = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (grant[i]) begin
        acc_idx = 3'(i);
        x_sel   = x_in[i*X_W +: X_W];
        y_sel   = y_in[i*Y_W +: Y_W];
        c_sel   = colour_in[i*C_W +: C_W];
      end
    end
    in_bounds = (x_sel <= X_LIM) && (y_sel <= Y_LIM);
  end

  // Next-state logic. Release depends only on the owner's lock, so an owner
  // that drops lock without a pixel still frees the arbiter.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    if (accept) begin
      ptr_d = acc_idx;
    end
    case (state_q)
      IDLE: begin
        if (accept && lock[acc_idx]) begin
          state_d = LOCKED;
          owner_d = acc_idx;
        end
      end
      LOCKED: begin
        if (!lock[owner_q]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Arbiter state registers. The pointer resets to the last channel so that
  // channel 0 wins the first round-robin search.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= 3'(N_CH - 1);
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
    end
  end

  assign busy  = (state_q == LOCKED);
  assign owner = owner_q;

  // Adapter output stage. Coordinates only move on an on-screen accept; in
  // every other cycle they hold, so the adapter never sees dummy values.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      x          <= '0;
      y          <= '0;
      colour     <= '0;
      plot       <= 1'b0;
      clip_count <= '0;
    end else begin
      plot <= accept && in_bounds;
      if (accept && in_bounds) begin
        x      <= x_sel;
        y      <= y_sel;
        colour <= c_sel;
      end
      if (accept && !in_bounds && (clip_count != 16'hFFFF)) begin
        clip_count <= clip_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_vga_plot_arbiter.sv
`timescale 1ns/1ps
// tb_vga_plot_arbiter
// Drives two arbiters side by side: index 0 in fixed-priority mode and
// index 1 in round-robin mode, each with its own request inputs. Stimulus
// pushes every pixel it expects to see plotted, tagged with the cycle it
// should appear in. A separate monitor pops that queue whenever the adapter
// side shows plot=1.
module tb_vga_plot_arbiter;

  localparam int N_CH = 5;
  localparam int X_W  = 9;
  localparam int Y_W  = 8;
  localparam int C_W  = 3;

  typedef struct {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic [C_W-1:0] c;
    int             cyc;
  } pix_t;

  logic clock = 1'b0;
  logic resetn;
  int   cyc = 0;

  logic [N_CH-1:0]           req_d  [2];
  logic [N_CH-1:0]           lock_d [2];
  logic [N_CH-1:0][X_W-1:0]  px     [2];
  logic [N_CH-1:0][Y_W-1:0]  py     [2];
  logic [N_CH-1:0][C_W-1:0]  pc     [2];

  logic [N_CH-1:0] grant_o [2];
  logic            busy_o  [2];
  logic [2:0]      owner_o [2];
  logic [X_W-1:0]  x_o     [2];
  logic [Y_W-1:0]  y_o     [2];
  logic [C_W-1:0]  c_o     [2];
  logic            plot_o  [2];
  logic [15:0]     clip_o  [2];

  pix_t sb_q [2][$];
  pix_t mon_e;
  int   n_compared = 0;
  int   n_mismatch = 0;
  int   ch;

  always #5 clock = ~clock;

  // Cycle counter, stepped on every rising edge.
  always @(posedge clock) cyc <= cyc + 1;

  vga_plot_arbiter #(.N_CH(N_CH), .RR_MODE(0)) dut_fp (
    .clock(clock), .resetn(resetn),
    .req(req_d[0]), .lock(lock_d[0]),
    .x_in(px[0]), .y_in(py[0]), .colour_in(pc[0]),
    .grant(grant_o[0]), .busy(busy_o[0]), .owner(owner_o[0]),
    .x(x_o[0]), .y(y_o[0]), .colour(c_o[0]), .plot(plot_o[0]),
    .clip_count(clip_o[0])
  );

  vga_plot_arbiter #(.N_CH(N_CH), .RR_MODE(1)) dut_rr (
    .clock(clock), .resetn(resetn),
    .req(req_d[1]), .lock(lock_d[1]),
    .x_in(px[1]), .y_in(py[1]), .colour_in(pc[1]),
    .grant(grant_o[1]), .busy(busy_o[1]), .owner(owner_o[1]),
    .x(x_o[1]), .y(y_o[1]), .colour(c_o[1]), .plot(plot_o[1]),
    .clip_count(clip_o[1])
  );

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] want);
    n_compared++;
    if (got !== want) begin
      n_mismatch++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic nextCycle();
    @(posedge clock);
    #2;
  endtask

  task automatic applyStimulus(input int d, input logic [N_CH-1:0] r, input logic [N_CH-1:0] l);
    req_d[d]  = r;
    lock_d[d] = l;
  endtask

  task automatic setPix(input int d, input int c_idx, input int xv, input int yv, input int cv);
    px[d][c_idx] = X_W'(xv);
    py[d][c_idx] = Y_W'(yv);
    pc[d][c_idx] = C_W'(cv);
  endtask

  // Pixel accepted in this cycle must show up on the next edge.
  task automatic expectPix(input int d, input int xv, input int yv, input int cv);
    pix_t e;
    e.x   = X_W'(xv);
    e.y   = Y_W'(yv);
    e.c   = C_W'(cv);
    e.cyc = cyc + 1;
    sb_q[d].push_back(e);
  endtask

  // Monitor: just after each edge, match any plot against the scoreboard
  // and flag expected pixels whose cycle passed without a plot.
  always @(posedge clock) begin
    #1;
    for (int d = 0; d < 2; d++) begin
      if (plot_o[d] === 1'b1) begin
        if (sb_q[d].size() == 0) begin
          n_compared++;
          n_mismatch++;
          $display("[TB] FAIL unexpected_plot dut%0d: got x=%0d y=%0d c=%0d, expected no plot (cycle %0d)",
                   d, x_o[d], y_o[d], c_o[d], cyc);
        end else begin
          mon_e = sb_q[d].pop_front();
          checkOutput($sformatf("pixel dut%0d {cyc,x,y,c}", d),
                      {16'(cyc), x_o[d], y_o[d], c_o[d]},
                      {16'(mon_e.cyc), mon_e.x, mon_e.y, mon_e.c});
        end
      end else if (sb_q[d].size() != 0 && sb_q[d][0].cyc <= cyc) begin
        mon_e = sb_q[d].pop_front();
        n_compared++;
        n_mismatch++;
        $display("[TB] FAIL missing_plot dut%0d: got plot=0, expected x=%0d y=%0d c=%0d at cycle %0d",
                 d, mon_e.x, mon_e.y, mon_e.c, mon_e.cyc);
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #1500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    resetn = 1'b1;
    for (int d = 0; d < 2; d++) begin
      req_d[d]  = '1;
      lock_d[d] = '0;
      px[d] = '0;
      py[d] = '0;
      pc[d] = '0;
    end
    #1 resetn = 1'b0;
    #2;
    // Reset state, with requests held high to prove grant is gated.
    checkOutput("reset grant fp", grant_o[0], 0);
    checkOutput("reset grant rr", grant_o[1], 0);
    checkOutput("reset plot", plot_o[0], 0);
    checkOutput("reset busy", busy_o[0], 0);
    checkOutput("reset owner", owner_o[0], 0);
    checkOutput("reset xyc", {x_o[0], y_o[0], c_o[0]}, 0);
    checkOutput("reset clip", clip_o[0], 0);
    nextCycle();
    resetn = 1'b1;
    applyStimulus(0, '0, '0);
    applyStimulus(1, '0, '0);

    // Fixed priority: ch1 beats ch2 and ch4.
    setPix(0, 1, 100, 50, 3);
    setPix(0, 2, 200, 60, 1);
    setPix(0, 4, 5, 6, 7);
    repeat (3) begin
      nextCycle();
      applyStimulus(0, 5'b10110, 5'b00000);
      expectPix(0, 100, 50, 3);
      #4 checkOutput("fp grant", grant_o[0], 5'b00010);
    end
    nextCycle();
    applyStimulus(0, '0, '0);

    // Clipping: off-right, exact corner, off-bottom.
    nextCycle();
    setPix(0, 0, 320, 10, 2);
    applyStimulus(0, 5'b00001, '0);
    #4 checkOutput("clip grant a", grant_o[0], 5'b00001);
    nextCycle();
    setPix(0, 0, 319, 239, 6);
    applyStimulus(0, 5'b00001, '0);
    expectPix(0, 319, 239, 6);
    #4 checkOutput("clip grant b", grant_o[0], 5'b00001);
    nextCycle();
    setPix(0, 0, 0, 240, 4);
    applyStimulus(0, 5'b00001, '0);
    #4 checkOutput("clip grant c", grant_o[0], 5'b00001);
    nextCycle();
    applyStimulus(0, '0, '0);
    #4 checkOutput("clip_count 2", clip_o[0], 2);
    checkOutput("clip hold xyc", {x_o[0], y_o[0], c_o[0]}, {9'd319, 8'd239, 3'd6});

    // Saturation: 65533 more clipped pixels reach 16'hFFFF, one more stays.
    nextCycle();
    setPix(0, 0, 400, 0, 1);
    applyStimulus(0, 5'b00001, '0);
    repeat (65533) @(posedge clock);
    #2 applyStimulus(0, '0, '0);
    #4 checkOutput("clip_count max", clip_o[0], 16'hFFFF);
    nextCycle();
    applyStimulus(0, 5'b00001, '0);
    nextCycle();
    applyStimulus(0, '0, '0);
    #4 checkOutput("clip_count saturated", clip_o[0], 16'hFFFF);

    // Burst lock: ch3 owns four pixels while ch0 waits.
    nextCycle();
    setPix(0, 3, 30, 3, 1);
    applyStimulus(0, 5'b01000, 5'b01000);
    expectPix(0, 30, 3, 1);
    #4 checkOutput("burst grant 0", grant_o[0], 5'b01000);
    for (int k = 1; k < 4; k++) begin
      nextCycle();
      setPix(0, 3, 30 + k, 3, k + 1);
      setPix(0, 0, 12, 34, 5);
      applyStimulus(0, 5'b01001, (k == 3) ? 5'b00000 : 5'b01000);
      expectPix(0, 30 + k, 3, k + 1);
      #4 checkOutput("burst grant", grant_o[0], 5'b01000);
      checkOutput("burst busy", busy_o[0], 1);
      checkOutput("burst owner", owner_o[0], 3);
    end
    nextCycle();
    applyStimulus(0, 5'b00001, '0);
    expectPix(0, 12, 34, 5);
    #4 checkOutput("burst release grant", grant_o[0], 5'b00001);
    checkOutput("burst release busy", busy_o[0], 0);

    // Idle hold after the last plot at (12,34,5).
    nextCycle();
    applyStimulus(0, '0, '0);
    repeat (2) begin
      nextCycle();
      #4 checkOutput("idle plot", plot_o[0], 0);
      checkOutput("idle hold xyc", {x_o[0], y_o[0], c_o[0]}, {9'd12, 8'd34, 3'd5});
    end

    // Owner gap: locked ch1 pauses, ch0 stays blocked until lock drops.
    nextCycle();
    setPix(0, 1, 7, 7, 7);
    applyStimulus(0, 5'b00010, 5'b00010);
    expectPix(0, 7, 7, 7);
    #4 checkOutput("gap grant 0", grant_o[0], 5'b00010);
    nextCycle();
    applyStimulus(0, 5'b00001, 5'b00010);
    #4 checkOutput("gap stall grant", grant_o[0], 0);
    checkOutput("gap busy", busy_o[0], 1);
    nextCycle();
    applyStimulus(0, 5'b00001, 5'b00000);
    #4 checkOutput("gap release grant", grant_o[0], 0);
    nextCycle();
    applyStimulus(0, 5'b00001, '0);
    expectPix(0, 12, 34, 5);
    #4 checkOutput("gap after grant", grant_o[0], 5'b00001);
    nextCycle();
    applyStimulus(0, '0, '0);

    // Round robin from reset: ch0,1,2,3,4,0.
    for (int i = 0; i < N_CH; i++) setPix(1, i, 20 + i, i, i);
    for (int k = 0; k < 6; k++) begin
      ch = k % N_CH;
      nextCycle();
      applyStimulus(1, 5'b11111, '0);
      expectPix(1, 20 + ch, ch, ch);
      #4 checkOutput("rr grant", grant_o[1], 64'(1 << ch));
    end
    nextCycle();
    applyStimulus(1, '0, '0);

    // Reset during a ch2 locked burst on the round-robin arbiter.
    nextCycle();
    applyStimulus(1, 5'b00100, 5'b00100);
    expectPix(1, 22, 2, 2);
    #4 checkOutput("rst burst grant", grant_o[1], 5'b00100);
    nextCycle();
    applyStimulus(1, 5'b00100, 5'b00100);
    #4 checkOutput("rst burst busy", busy_o[1], 1);
    checkOutput("rst burst owner", owner_o[1], 2);
    resetn = 1'b0;
    #1 checkOutput("mid reset grant", grant_o[1], 0);
    checkOutput("mid reset busy", busy_o[1], 0);
    checkOutput("mid reset owner", owner_o[1], 0);
    checkOutput("mid reset plot/xyc", {plot_o[1], x_o[1], y_o[1], c_o[1]}, 0);
    checkOutput("mid reset clip fp", clip_o[0], 0);
    nextCycle();
    resetn = 1'b1;
    applyStimulus(1, 5'b11111, '0);
    expectPix(1, 20, 0, 0);
    #4 checkOutput("post reset rr grant", grant_o[1], 5'b00001);
    nextCycle();
    applyStimulus(1, '0, '0);
    repeat (3) nextCycle();

    checkOutput("scoreboard fp drained", sb_q[0].size(), 0);
    checkOutput("scoreboard rr drained", sb_q[1].size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule
